// File: rtl/gcd_mod_unit.sv
// gcd_mod_unit: multi-cycle remainder/quotient unit for the GCD datapath.
// Restoring shift-subtract division, one quotient bit per clock, so a
// WIDTH-bit operation takes WIDTH+1 edges from accept to done regardless of
// the operand values. A zero divisor short-circuits to a one-edge result.
module gcd_mod_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o,
  output logic             div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   rem_out_q, rem_out_d;
  logic [WIDTH-1:0]   quot_out_q, quot_out_d;
  logic               dbz_q, dbz_d;

  // One restoring-division step: partial remainder shifted left with the
  // next dividend bit, trial-subtracted against the divisor.
  logic [WIDTH+1:0]   t;
  logic               t_ge_b;
  logic [WIDTH:0]     rem_step;
  logic [WIDTH-1:0]   shift_step;
  logic               last_iter;

  // Combinational datapath for a single iteration of the divider.
  always_comb begin
    // The full partial remainder (including its guard bit) takes part in the
    // compare; the guard bit stays zero because rem_q < b_q after every step.
    t          = {rem_q, shift_q[WIDTH-1]};
    t_ge_b     = (t >= {2'b00, b_q});
    rem_step   = t_ge_b ? (t[WIDTH:0] - {1'b0, b_q}) : t[WIDTH:0];
    shift_step = {shift_q[WIDTH-2:0], t_ge_b};
    last_iter  = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and next-output logic for the IDLE/RUN controller.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    shift_d    = shift_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rem_out_d  = rem_out_q;
    quot_out_d = quot_out_q;
    dbz_d      = dbz_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (b_i != '0) begin
            shift_d = a_i;
            b_d     = b_i;
            rem_d   = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            // Zero divisor: report the dividend as the remainder and a
            // saturated quotient without entering the iteration loop.
            rem_out_d  = a_i;
            quot_out_d = '1;
            dbz_d      = 1'b1;
            done_d     = 1'b1;
          end
        end
      end

      RUN: begin
        rem_d   = rem_step;
        shift_d = shift_step;
        cnt_d   = cnt_q + 1'b1;
        if (last_iter) begin
          rem_out_d  = rem_step[WIDTH-1:0];
          quot_out_d = shift_step;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset clears the controller and every result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      shift_q    <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rem_out_q  <= '0;
      quot_out_q <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      shift_q    <= shift_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rem_out_q  <= rem_out_d;
      quot_out_q <= quot_out_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign rem_o         = rem_out_q;
  assign quot_o        = quot_out_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_gcd_mod_unit.sv
// Scoreboard bench for gcd_mod_unit: the driver predicts each accepted
// operation with plain / and % and queues it; a monitor checks every cycle.
module tb_gcd_mod_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] rem_o;
  logic [W-1:0] quot_o;
  logic         div_by_zero_o;

  gcd_mod_unit #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .rem_o         (rem_o),
    .quot_o        (quot_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] rem;
    logic [W-1:0] quot;
    logic         dbz;
    int           acc;
    int           due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one start request for a cycle; queue the prediction if the unit
  // will be idle at the sampling edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit   idle;
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    idle = (q.size() == 0) || q[$].dbz || (cyc + 1 > q[$].due);
    if (idle) begin
      e.acc  = cyc + 1;
      e.dbz  = (b == 0);
      e.rem  = (b == 0) ? a : W'(a % b);
      e.quot = (b == 0) ? {W{1'b1}} : W'(a / b);
      e.due  = (b == 0) ? cyc + 1 : cyc + 1 + W;
      q.push_back(e);
    end
    @(negedge clk);
    start_i = 1'b0;
    a_i     = W'($urandom);
    b_i     = W'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("idle_timeout", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_rem"},  32'(rem_o),  32'd0);
    chk({tag, "_quot"}, 32'(quot_o), 32'd0);
    chk({tag, "_dbz"},  32'(div_by_zero_o), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 q.delete();
    @(negedge clk);
    check_cleared("midrun_reset");
    rst = 1'b0;
  endtask

  // Monitor: busy is predicted from the queued operations, and every due
  // result is compared in the cycle it must appear.
  logic busy_exp;
  exp_t m;
  always @(negedge clk) begin
    if (!rst) begin
      busy_exp = 1'b0;
      foreach (q[i])
        if (!q[i].dbz && cyc >= q[i].acc && cyc < q[i].due) busy_exp = 1'b1;
      chk("busy", 32'(busy_o), 32'(busy_exp));
      if (q.size() > 0 && q[0].due == cyc) begin
        m = q.pop_front();
        chk("done", 32'(done_o), 32'd1);
        chk("rem",  32'(rem_o),  32'(m.rem));
        chk("quot", 32'(quot_o), 32'(m.quot));
        chk("dbz",  32'(div_by_zero_o), 32'(m.dbz));
      end else if (done_o) begin
        chk("spurious_done", 32'(done_o), 32'd0);
      end
    end
  end

  logic [W-1:0] ra, rb;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic operation and zero divisor.
    issue(16'd48, 16'd18);    wait_idle();
    issue(16'h1234, 16'd0);   wait_idle();
    issue(16'd5, 16'd7);      wait_idle();
    issue(16'hFFFF, 16'd1);   wait_idle();
    issue(16'hFFFF, 16'hFFFF); wait_idle();

    // Start while busy is ignored.
    issue(16'd100, 16'd7);
    repeat (4) @(negedge clk);
    issue(16'd9, 16'd4);
    wait_idle();

    // Reset in the middle of a run, then the same operation again.
    issue(16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    pulse_reset();
    @(negedge clk);
    issue(16'd1000, 16'd3);   wait_idle();

    // Back-to-back: second start during the done cycle of the first.
    issue(16'd48, 16'd18);
    for (int i = 0; i < 40 && !done_o; i++) @(negedge clk);
    issue(16'd35, 16'd10);
    wait_idle();

    // Two zero-divisor starts on consecutive edges.
    issue(16'd77, 16'd0);
    issue(16'd88, 16'd0);
    wait_idle();

    // Random traffic, including starts that land while busy.
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      ra = W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 300));
        3:       rb = ra;
        default: rb = W'($urandom);
      endcase
      issue(ra, rb);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
